// File: rtl/uart_frame_decoder_pkg.sv
// ============================================================================
// Module      : uart_frame_decoder_pkg
// Description : Shared frame layout constants, error codes and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_frame_decoder_pkg;

    localparam int FRAME_BYTES  = 8;
    localparam int IDX_ADDR     = 1;
    localparam int IDX_DATA_MSB = 2;
    localparam int IDX_CHK      = FRAME_BYTES - 1;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CHK  = 2'd1,
        ERR_ADDR = 2'd2,
        ERR_TMO  = 2'd3
    } err_code_e;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_frame_timeout.sv
// ============================================================================
// Module      : uart_frame_timeout
// Description : Loadable cycle counter with clear/enable; flags the last count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_timeout #(
    parameter int LIMIT = 200000,
    parameter int WIDTH = $clog2(LIMIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // Counter parks on the last value so expire stays asserted until cleared
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !expire) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_frame_decoder.sv
// ============================================================================
// Module      : uart_frame_decoder
// Description : Assembles 8-byte UART command frames into 32-bit cfg writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         NUM_REGS       = 16,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        cfg_wr,
    output logic [7:0]  cfg_addr,
    output logic [31:0] cfg_data,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam int         TMO_W         = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0] FIRST_PAYLOAD = 3'(IDX_ADDR);
    localparam logic [2:0] LAST_PAYLOAD  = 3'(IDX_DATA_MSB + 3);
    localparam logic [2:0] LAST_IDX      = 3'(IDX_CHK);
    localparam logic [8:0] REG_LIMIT     = 9'(NUM_REGS);

    state_e      state;
    state_e      state_next;
    logic [2:0]  idx;
    logic [7:0]  chk;
    logic [39:0] payload;
    logic        tmo_expire;
    logic        tmo_clr;
    logic        chk_fail;
    logic        addr_fail;
    logic        accept;
    logic        reject;
    err_code_e   err_next;

    uart_frame_timeout #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TMO_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmo_clr),
        .en       (state == COLLECT),
        .load     (1'b0),
        .load_val ({TMO_W{1'b0}}),
        .expire   (tmo_expire)
    );

    // Any byte restarts the inter-byte window; leaving COLLECT parks it at 0
    assign tmo_clr = byte_valid || (state_next == HUNT);
    assign busy    = (state == COLLECT);

    always_comb begin
        state_next = state;
        chk_fail   = 1'b0;
        addr_fail  = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        err_next   = ERR_NONE;
        case (state)
            HUNT: begin
                if (byte_valid && byte_in == SYNC_BYTE) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    if (idx == LAST_IDX) begin
                        state_next = HUNT;
                        chk_fail   = (chk != byte_in);
                        addr_fail  = !chk_fail && ({1'b0, payload[39:32]} >= REG_LIMIT);
                        accept     = !chk_fail && !addr_fail;
                        reject     = chk_fail || addr_fail;
                        err_next   = chk_fail ? ERR_CHK : (addr_fail ? ERR_ADDR : ERR_NONE);
                    end
                end else if (tmo_expire) begin
                    state_next = HUNT;
                    reject     = 1'b1;
                    err_next   = ERR_TMO;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            idx       <= '0;
            chk       <= '0;
            payload   <= '0;
            cfg_wr    <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            err_cnt   <= '0;
        end else begin
            state     <= state_next;
            cfg_wr    <= accept;
            frame_ok  <= accept;
            frame_err <= reject;
            if (accept) begin
                cfg_addr <= payload[39:32];
                cfg_data <= payload[31:0];
            end
            if (reject) begin
                err_code <= err_next;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
            if (state == HUNT) begin
                if (byte_valid && byte_in == SYNC_BYTE) begin
                    idx <= 3'd1;
                    chk <= SYNC_BYTE;
                end
            end else if (byte_valid) begin
                chk <= chk ^ byte_in;
                idx <= idx + 3'd1;
                if (idx >= FIRST_PAYLOAD && idx <= LAST_PAYLOAD) begin
                    payload <= {payload[31:0], byte_in};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
// ============================================================================
// Module      : tb_uart_frame_decoder
// Description : Randomized and directed checks of uart_frame_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_frame_decoder;

    localparam int         TMO   = 40;
    localparam int         NREGS = 16;
    localparam logic [7:0] SYNC  = 8'hA5;

    typedef logic [63:0] frame_t;
    typedef struct { int cyc; logic [7:0] addr; logic [31:0] data; } wr_ev_t;
    typedef struct { int cyc; logic [1:0] code; logic [7:0] cnt; } err_ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        cfg_wr, frame_ok, frame_err, busy;
    logic [7:0]  cfg_addr, err_cnt;
    logic [31:0] cfg_data;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_edge = 0;
    int exp_cnt = 0;
    logic [7:0]  exp_addr = 8'h00;
    logic [31:0] exp_data = 32'h0;

    wr_ev_t  wr_q[$];
    err_ev_t err_q[$];
    int      ok_q[$];

    uart_frame_decoder #(
        .SYNC_BYTE      (SYNC),
        .NUM_REGS       (NREGS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        wr_ev_t  w;
        err_ev_t e;
        if (cfg_wr === 1'b1) begin
            w.cyc = cyc; w.addr = cfg_addr; w.data = cfg_data;
            wr_q.push_back(w);
        end
        if (frame_ok === 1'b1) ok_q.push_back(cyc);
        if (frame_err === 1'b1) begin
            e.cyc = cyc; e.code = err_code; e.cnt = err_cnt;
            err_q.push_back(e);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    // Reference: frame built and judged purely from byte-level rules
    function automatic frame_t make_frame(input logic [7:0] a, input logic [31:0] d,
                                          input logic [7:0] fl);
        logic [55:0] body;
        logic [7:0]  x;
        body = {SYNC, a, d, fl};
        x = 8'h00;
        for (int i = 0; i < 7; i++) x ^= body[8*i +: 8];
        return {body, x};
    endfunction

    function automatic int verdict(input frame_t f);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 7; i++) x ^= f[63-8*i -: 8];
        if (x != f[7:0]) return 1;
        if (int'(f[55:48]) >= NREGS) return 2;
        return 0;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        last_edge = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input frame_t f, input int gap);
        for (int i = 0; i < 8; i++) begin
            send_byte(f[63-8*i -: 8]);
            if (i < 7) idle(gap < 0 ? int'($urandom_range(0, TMO - 1)) : gap);
        end
    endtask

    task automatic clear_q();
        wr_q.delete(); err_q.delete(); ok_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_cmp++;
        if ({cfg_wr, cfg_addr, cfg_data, frame_ok, frame_err, err_code, err_cnt, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got wr=%b addr=%h data=%h ok=%b err=%b code=%0d cnt=%0d busy=%b, want all 0",
                     cfg_wr, cfg_addr, cfg_data, frame_ok, frame_err, err_code, err_cnt, busy);
        end
        rst = 1'b0;
        idle(2);
        clear_q();
    endtask

    task automatic test_good_frame();
        frame_t f;
        clear_q();
        f = make_frame(8'h03, 32'h12345678, 8'h00);
        send_frame(f, 9);
        idle(3);
        n_cmp++;
        if (wr_q.size() !== 1) begin
            n_bad++; $display("FAIL good_wr_count: got %0d want 1", wr_q.size());
        end else begin
            n_cmp++;
            if ({wr_q[0].cyc, wr_q[0].addr, wr_q[0].data} !== {last_edge, 8'h03, 32'h12345678}) begin
                n_bad++;
                $display("FAIL good_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=03 data=12345678",
                         wr_q[0].cyc, wr_q[0].addr, wr_q[0].data, last_edge);
            end
        end
        n_cmp++;
        if (ok_q.size() !== 1 || ok_q[0] !== last_edge) begin
            n_bad++; $display("FAIL good_frame_ok: got %0d pulses want 1 at cyc %0d", ok_q.size(), last_edge);
        end
        n_cmp++;
        if (err_q.size() !== 0 || err_cnt !== 8'd0) begin
            n_bad++; $display("FAIL good_no_err: got %0d err pulses cnt=%0d want 0/0", err_q.size(), err_cnt);
        end
        exp_addr = 8'h03; exp_data = 32'h12345678;
    endtask

    task automatic test_bad_checksum();
        frame_t f;
        clear_q();
        f = make_frame(8'h03, 32'h12345678, 8'h00);
        f[7:0] = 8'h8F;
        send_frame(f, 2);
        idle(3);
        exp_cnt++;
        n_cmp++;
        if (err_q.size() !== 1 || wr_q.size() !== 0) begin
            n_bad++; $display("FAIL chk_counts: got err=%0d wr=%0d want 1/0", err_q.size(), wr_q.size());
        end else begin
            n_cmp++;
            if ({err_q[0].cyc, err_q[0].code, err_q[0].cnt} !== {last_edge, 2'd1, 8'(exp_cnt)}) begin
                n_bad++;
                $display("FAIL chk_err: got cyc=%0d code=%0d cnt=%0d want cyc=%0d code=1 cnt=%0d",
                         err_q[0].cyc, err_q[0].code, err_q[0].cnt, last_edge, exp_cnt);
            end
        end
        clear_q();
        f = make_frame(8'h07, 32'hCAFEF00D, 8'h5A);
        send_frame(f, 0);
        idle(3);
        n_cmp++;
        if (wr_q.size() !== 1 || err_q.size() !== 0) begin
            n_bad++; $display("FAIL chk_recover: got wr=%0d err=%0d want 1/0", wr_q.size(), err_q.size());
        end else begin
            n_cmp++;
            if ({wr_q[0].addr, wr_q[0].data} !== {8'h07, 32'hCAFEF00D}) begin
                n_bad++; $display("FAIL chk_recover_data: got %h/%h want 07/cafef00d", wr_q[0].addr, wr_q[0].data);
            end
        end
        exp_addr = 8'h07; exp_data = 32'hCAFEF00D;
    endtask

    task automatic test_bad_addr();
        frame_t f;
        clear_q();
        f = make_frame(8'h10, 32'h00000001, 8'h00);
        send_frame(f, 1);
        idle(3);
        exp_cnt++;
        n_cmp++;
        if (err_q.size() !== 1 || wr_q.size() !== 0) begin
            n_bad++; $display("FAIL addr_counts: got err=%0d wr=%0d want 1/0", err_q.size(), wr_q.size());
        end else begin
            n_cmp++;
            if ({err_q[0].cyc, err_q[0].code, err_q[0].cnt} !== {last_edge, 2'd2, 8'(exp_cnt)}) begin
                n_bad++;
                $display("FAIL addr_err: got cyc=%0d code=%0d cnt=%0d want cyc=%0d code=2 cnt=%0d",
                         err_q[0].cyc, err_q[0].code, err_q[0].cnt, last_edge, exp_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        int ref_edge;
        clear_q();
        send_byte(8'h00); idle(3);
        send_byte(8'hFF);
        idle(TMO + 5);
        n_cmp++;
        if (err_q.size() !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL hunt_ignore: got err=%0d busy=%b want 0/0", err_q.size(), busy);
        end
        send_byte(SYNC);
        send_byte(8'h05);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL tmo_busy: got busy=%b want 1", busy);
        end
        idle(TMO - 1);
        send_byte(8'h11);
        ref_edge = last_edge;
        idle(TMO - 1);
        n_cmp++;
        if (err_q.size() !== 0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL tmo_limit_byte: got err=%0d busy=%b want 0/1", err_q.size(), busy);
        end
        idle(3);
        exp_cnt++;
        n_cmp++;
        if (err_q.size() !== 1) begin
            n_bad++; $display("FAIL tmo_count: got %0d err pulses want 1", err_q.size());
        end else begin
            n_cmp++;
            if ({err_q[0].cyc, err_q[0].code, err_q[0].cnt} !== {ref_edge + TMO, 2'd3, 8'(exp_cnt)}) begin
                n_bad++;
                $display("FAIL tmo_err: got cyc=%0d code=%0d cnt=%0d want cyc=%0d code=3 cnt=%0d",
                         err_q[0].cyc, err_q[0].code, err_q[0].cnt, ref_edge + TMO, exp_cnt);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || wr_q.size() !== 0) begin
            n_bad++; $display("FAIL tmo_after: got busy=%b wr=%0d want 0/0", busy, wr_q.size());
        end
    endtask

    task automatic test_back_to_back();
        frame_t f1, f2;
        int e1;
        clear_q();
        f1 = make_frame(8'($urandom_range(0, NREGS - 1)), $urandom, 8'($urandom));
        f2 = make_frame(8'($urandom_range(0, NREGS - 1)), $urandom, 8'($urandom));
        send_frame(f1, 0);
        e1 = last_edge;
        send_frame(f2, 0);
        idle(3);
        n_cmp++;
        if (wr_q.size() !== 2) begin
            n_bad++; $display("FAIL b2b_count: got %0d writes want 2", wr_q.size());
        end else begin
            n_cmp++;
            if ({wr_q[0].cyc, wr_q[0].addr, wr_q[0].data} !== {e1, f1[55:16]}) begin
                n_bad++; $display("FAIL b2b_first: got cyc=%0d %h/%h want cyc=%0d %h/%h",
                                  wr_q[0].cyc, wr_q[0].addr, wr_q[0].data, e1, f1[55:48], f1[47:16]);
            end
            n_cmp++;
            if ({wr_q[1].cyc, wr_q[1].addr, wr_q[1].data} !== {e1 + 8, f2[55:16]}) begin
                n_bad++; $display("FAIL b2b_second: got cyc=%0d %h/%h want cyc=%0d %h/%h",
                                  wr_q[1].cyc, wr_q[1].addr, wr_q[1].data, e1 + 8, f2[55:48], f2[47:16]);
            end
        end
        exp_addr = f2[55:48]; exp_data = f2[47:16];
    endtask

    task automatic test_random();
        frame_t     f;
        logic [7:0] a, b;
        int         mode, v;
        for (int k = 0; k < 30; k++) begin
            clear_q();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h5A;
                send_byte(b);
                idle($urandom_range(0, 3));
            end
            mode = $urandom_range(0, 2);
            a = (mode == 2) ? 8'($urandom_range(NREGS, 255)) : 8'($urandom_range(0, NREGS - 1));
            f = make_frame(a, $urandom, 8'($urandom));
            if (mode == 1) f[7:0] ^= 8'($urandom_range(1, 255));
            v = verdict(f);
            send_frame(f, -1);
            idle(3);
            if (v != 0 && exp_cnt < 255) exp_cnt++;
            n_cmp++;
            if (wr_q.size() !== (v == 0 ? 1 : 0) || err_q.size() !== (v == 0 ? 0 : 1)) begin
                n_bad++; $display("FAIL rand_counts[%0d]: got wr=%0d err=%0d for verdict %0d", k, wr_q.size(), err_q.size(), v);
            end else if (v == 0) begin
                exp_addr = f[55:48]; exp_data = f[47:16];
                n_cmp++;
                if ({wr_q[0].cyc, wr_q[0].addr, wr_q[0].data} !== {last_edge, exp_addr, exp_data}) begin
                    n_bad++; $display("FAIL rand_write[%0d]: got cyc=%0d %h/%h want cyc=%0d %h/%h",
                                      k, wr_q[0].cyc, wr_q[0].addr, wr_q[0].data, last_edge, exp_addr, exp_data);
                end
            end else begin
                n_cmp++;
                if ({err_q[0].cyc, err_q[0].code, err_q[0].cnt} !== {last_edge, 2'(v), 8'(exp_cnt)}) begin
                    n_bad++; $display("FAIL rand_err[%0d]: got cyc=%0d code=%0d cnt=%0d want cyc=%0d code=%0d cnt=%0d",
                                      k, err_q[0].cyc, err_q[0].code, err_q[0].cnt, last_edge, v, exp_cnt);
                end
            end
            n_cmp++;
            if ({cfg_addr, cfg_data} !== {exp_addr, exp_data}) begin
                n_bad++; $display("FAIL rand_hold[%0d]: got %h/%h want %h/%h", k, cfg_addr, cfg_data, exp_addr, exp_data);
            end
        end
    endtask

    task automatic test_saturation();
        frame_t f;
        clear_q();
        for (int k = 0; k < 260; k++) begin
            f = make_frame(8'($urandom_range(0, NREGS - 1)), $urandom, 8'h00);
            f[7:0] = ~f[7:0];
            send_frame(f, 0);
        end
        idle(3);
        exp_cnt = 255;
        n_cmp++;
        if (err_q.size() !== 260 || wr_q.size() !== 0) begin
            n_bad++; $display("FAIL sat_counts: got err=%0d wr=%0d want 260/0", err_q.size(), wr_q.size());
        end else begin
            n_cmp++;
            if (err_q[259].cnt !== 8'd255 || err_q[1].cyc - err_q[0].cyc !== 8) begin
                n_bad++; $display("FAIL sat_last: got cnt=%0d spacing=%0d want 255/8",
                                  err_q[259].cnt, err_q[1].cyc - err_q[0].cyc);
            end
        end
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_bad++; $display("FAIL sat_cnt: got %0d want 255", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        clear_q();
        send_byte(SYNC); send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(TMO + 5);
        exp_cnt = 0; exp_addr = 8'h00; exp_data = 32'h0;
        n_cmp++;
        if (busy !== 1'b0 || err_cnt !== 8'd0 || err_q.size() !== 0 || wr_q.size() !== 0 || ok_q.size() !== 0) begin
            n_bad++; $display("FAIL rstmid_state: got busy=%b cnt=%0d err=%0d wr=%0d ok=%0d want all 0",
                              busy, err_cnt, err_q.size(), wr_q.size(), ok_q.size());
        end
        f = make_frame(8'h0F, 32'hA5A5_0001, 8'hA5);
        send_frame(f, 1);
        idle(3);
        n_cmp++;
        if (wr_q.size() !== 1 || err_q.size() !== 0) begin
            n_bad++; $display("FAIL rstmid_next_count: got wr=%0d err=%0d want 1/0", wr_q.size(), err_q.size());
        end else begin
            n_cmp++;
            if ({wr_q[0].cyc, wr_q[0].addr, wr_q[0].data} !== {last_edge, 8'h0F, 32'hA5A5_0001}) begin
                n_bad++; $display("FAIL rstmid_next: got cyc=%0d %h/%h want cyc=%0d 0f/a5a50001",
                                  wr_q[0].cyc, wr_q[0].addr, wr_q[0].data, last_edge);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_addr();
        test_timeout();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
